// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, legal-opcode check and default width shared by the ALU and its issue stage
package alu_pkg;
   localparam int W_DEF = 16;
   typedef enum logic [3:0] {
      OP_NOOP  = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_MULT  = 4'd3,
      OP_DIV   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_NOT   = 4'd8,
      OP_RESET = 4'd15
   } opcode_e;
   // 9..14 are unassigned encodings
   function automatic logic is_legal(input logic [3:0] op);
      return op <= 4'd8 || op == 4'd15;
   endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH x WIDTH register FIFO; caller must gate push with !full and pop with !empty
// Ports: clk, clear (async reset), push/din write side, pop/dout read side (dout shows head),
// count occupancy, full, empty.
module cmd_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   assign dout  = mem[rd];
   assign full  = count == FULL_CNT;
   assign empty = count == '0;
   // storage needs no reset: a clear rewinds the pointers, which discards the contents
   always_ff @(posedge clk)
      if (push) mem[wr] <= din;
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      end
endmodule

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: buffers ALU commands and issues one per cycle, screening bad opcodes and divide-by-zero to NOOP
// Ports: clk, clear (async reset); in_valid/in_ready/in_opcode/in_a/in_b command input;
// stall suppresses issue; alu_opcode/alu_input1/alu_input2/issue_valid registered ALU drive;
// count FIFO occupancy; err_bad_op/err_div0 sticky flags cleared by err_clr.
module alu_cmd_issue
   import alu_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_opcode,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   input  logic          stall,
   output logic [3:0]    alu_opcode,
   output logic [W-1:0]  alu_input1,
   output logic [W-1:0]  alu_input2,
   output logic          issue_valid,
   output logic [CW-1:0] count,
   output logic          err_bad_op,
   output logic          err_div0,
   input  logic          err_clr
);
   logic [2*W+3:0] head;
   logic full, empty, push, pop, bad, div0;
   logic [3:0] h_op;
   logic [W-1:0] h_a, h_b;
   cmd_fifo #(.WIDTH(2*W+4), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .clear(clear), .push(push), .din({in_opcode, in_a, in_b}),
      .pop(pop), .dout(head), .count(count), .full(full), .empty(empty)
   );
   assign in_ready = !full;
   assign push = in_valid && !full;
   assign pop  = !stall && !empty;
   assign {h_op, h_a, h_b} = head;
   assign bad  = !is_legal(h_op);
   // bad opcode takes priority, so a divide-by-zero flag only comes from a genuine DIV
   assign div0 = !bad && h_op == OP_DIV && h_b == '0;
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         alu_opcode  <= OP_NOOP;
         alu_input1  <= '0;
         alu_input2  <= '0;
         issue_valid <= 1'b0;
         err_bad_op  <= 1'b0;
         err_div0    <= 1'b0;
      end else begin
         // idle cycles issue NOOP with operands held so the ALU recirculates its result
         alu_opcode  <= (pop && !bad && !div0) ? h_op : OP_NOOP;
         issue_valid <= pop;
         if (pop) begin
            alu_input1 <= h_a;
            alu_input2 <= h_b;
         end
         err_bad_op <= (pop && bad) || (err_bad_op && !err_clr);
         err_div0   <= (pop && div0) || (err_div0 && !err_clr);
      end
endmodule
